// File: rtl/square_wave_meas.sv
// Square-wave phase meter: measures high/low phase lengths of an
// asynchronous input in clock cycles and reports each full period.
module square_wave_meas #(
   parameter int N           = 4,
   parameter int SYNC_STAGES = 2
) (
   input  logic         clock,
   input  logic         reset,
   input  logic         insignal,
   output logic [N-1:0] m_out,
   output logic [N-1:0] n_out,
   output logic         valid,
   output logic         locked,
   output logic         overflow,
   output logic         stalled
);

   typedef enum logic [1:0] {
      IDLE,
      MEAS_HIGH,
      MEAS_LOW
   } state_t;

   localparam logic [N-1:0] CNT_MAX = {N{1'b1}};
   localparam logic [N-1:0] CNT_ONE = {{(N-1){1'b0}}, 1'b1};

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic                   s_d_q, s_d_d;
   logic [N-1:0]           cnt_q, cnt_d;
   logic [N-1:0]           hi_len_q, hi_len_d;
   logic                   hi_ovf_q, hi_ovf_d;
   logic [N-1:0]           m_q, m_d;
   logic [N-1:0]           n_q, n_d;
   logic                   ovf_q, ovf_d;
   logic                   valid_q, valid_d;
   logic                   locked_q, locked_d;

   logic         s;
   logic         rise;
   logic         fall;
   logic         cnt_sat;
   logic [N-1:0] cnt_inc;

   assign sync_d  = {sync_q[SYNC_STAGES-2:0], insignal};
   assign s       = sync_q[SYNC_STAGES-1];
   assign s_d_d   = s;
   assign rise    = s & ~s_d_q;
   assign fall    = ~s & s_d_q;
   assign cnt_sat = (cnt_q == CNT_MAX);
   assign cnt_inc = cnt_sat ? cnt_q : cnt_q + CNT_ONE;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q  <= IDLE;
         sync_q   <= '0;
         s_d_q    <= 1'b0;
         cnt_q    <= '0;
         hi_len_q <= '0;
         hi_ovf_q <= 1'b0;
         m_q      <= '0;
         n_q      <= '0;
         ovf_q    <= 1'b0;
         valid_q  <= 1'b0;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         s_d_q    <= s_d_d;
         cnt_q    <= cnt_d;
         hi_len_q <= hi_len_d;
         hi_ovf_q <= hi_ovf_d;
         m_q      <= m_d;
         n_q      <= n_d;
         ovf_q    <= ovf_d;
         valid_q  <= valid_d;
         locked_q <= locked_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:      if (rise) state_d = MEAS_HIGH;
         MEAS_HIGH: if (fall) state_d = MEAS_LOW;
         MEAS_LOW:  if (rise) state_d = MEAS_HIGH;
         default:   state_d = IDLE;
      endcase
   end

   // The edge cycle itself is cycle 1 of the new phase.
   always_comb begin
      cnt_d    = cnt_q;
      hi_len_d = hi_len_q;
      hi_ovf_d = hi_ovf_q;
      m_d      = m_q;
      n_d      = n_q;
      ovf_d    = ovf_q;
      valid_d  = 1'b0;
      locked_d = locked_q;
      unique case (state_q)
         IDLE: begin
            if (rise) cnt_d = CNT_ONE;
         end
         MEAS_HIGH: begin
            if (fall) begin
               hi_len_d = cnt_q;
               hi_ovf_d = cnt_sat;
               cnt_d    = CNT_ONE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         MEAS_LOW: begin
            if (rise) begin
               m_d      = hi_len_q;
               n_d      = cnt_q;
               ovf_d    = hi_ovf_q | cnt_sat;
               valid_d  = 1'b1;
               locked_d = 1'b1;
               cnt_d    = CNT_ONE;
            end else begin
               cnt_d = cnt_inc;
            end
         end
         default: cnt_d = '0;
      endcase
   end

   always_comb begin
      m_out    = m_q;
      n_out    = n_q;
      valid    = valid_q;
      locked   = locked_q;
      overflow = ovf_q;
      stalled  = (state_q != IDLE) && cnt_sat;
   end

endmodule
